// File: rtl/sdram_arbiter.sv
// Two-master Avalon-MM arbiter in front of the single SDRAM controller port.
// Display reads win by default; the rasterizer is promoted after STARVE_LIMIT lost cycles.
module sdram_arbiter #(
    parameter int ADDR_W       = 25,
    parameter int DATA_W       = 16,
    parameter int MAX_PENDING  = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata,
    input  logic                  s_readdatavalid,

    output logic                  err_unexpected
);

    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_M0   = 2'd1;
    localparam logic [1:0] GNT_M1   = 2'd2;

    localparam logic [CNT_W-1:0] FIFO_DEPTH = CNT_W'(MAX_PENDING);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    logic [1:0]             grant_q;
    logic [1:0]             grant;
    logic                   lock_q;

    logic [MAX_PENDING-1:0] tag_mem;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;

    logic [STV_W-1:0]       starve;
    logic                   rdv0_q;
    logic                   rdv1_q;
    logic [DATA_W-1:0]      rdata_q;
    logic                   err_q;

    logic                   m1_req;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   pop;
    logic                   push;
    logic                   read_ok;
    logic                   m0_elig;
    logic                   m1_elig;
    logic                   cmd;
    logic                   accept;

    assign m1_req     = m1_read | m1_write;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FIFO_DEPTH);
    assign pop        = s_readdatavalid & ~fifo_empty;

    // A pop in the same cycle frees the slot a new read would take.
    assign read_ok = ~fifo_full | pop;
    assign m0_elig = m0_read & read_ok;
    assign m1_elig = m1_write | (m1_read & read_ok);

    always_comb begin
        grant = GNT_NONE;
        if (!reset_n)
            grant = GNT_NONE;
        else if (lock_q)
            grant = grant_q;
        else if (m1_elig && (starve == STARVE_MAX))
            grant = GNT_M1;
        else if (m0_elig)
            grant = GNT_M0;
        else if (m1_elig)
            grant = GNT_M1;
    end

    always_comb begin
        s_address    = m0_address;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_writedata  = m1_writedata;
        s_byteenable = '0;
        case (grant)
            GNT_M0: begin
                s_read       = m0_read;
                s_byteenable = '1;
            end
            GNT_M1: begin
                s_address    = m1_address;
                s_read       = m1_read;
                s_write      = m1_write;
                s_byteenable = m1_byteenable;
            end
            default: ;
        endcase
    end

    assign cmd    = s_read | s_write;
    assign accept = cmd & ~s_waitrequest;
    assign push   = accept & s_read;

    assign m0_waitrequest = (grant == GNT_M0) ? s_waitrequest : 1'b1;
    assign m1_waitrequest = (grant == GNT_M1) ? s_waitrequest : 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant_q <= GNT_NONE;
            lock_q  <= 1'b0;
            tag_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            starve  <= '0;
            rdv0_q  <= 1'b0;
            rdv1_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            grant_q <= grant;
            // A presented but stalled command must be held to the same master.
            lock_q  <= cmd & s_waitrequest;

            if (push) begin
                tag_mem[wr_ptr] <= (grant == GNT_M1);
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            if (!m1_req || (accept && (grant == GNT_M1)))
                starve <= '0;
            else if (starve != STARVE_MAX)
                starve <= starve + 1'b1;

            rdv0_q <= pop & ~tag_mem[rd_ptr];
            rdv1_q <= pop &  tag_mem[rd_ptr];

            if (s_readdatavalid && fifo_empty)
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (s_readdatavalid)
            rdata_q <= s_readdata;
    end

    assign m0_readdata      = rdata_q;
    assign m1_readdata      = rdata_q;
    assign m0_readdatavalid = rdv0_q;
    assign m1_readdatavalid = rdv1_q;
    assign err_unexpected   = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: in-order SDRAM slave model plus per-master expected-data queues.
module tb_sdram_arbiter;

    localparam int ADDR_W       = 25;
    localparam int DATA_W       = 16;
    localparam int MAX_PENDING  = 8;
    localparam int STARVE_LIMIT = 16;
    localparam int LAT          = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] m0_address;
    logic              m0_read;
    logic              m0_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;
    logic [ADDR_W-1:0] m1_address;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic [1:0]        m1_byteenable;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;
    logic [ADDR_W-1:0] s_address;
    logic              s_read;
    logic              s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [1:0]        s_byteenable;
    logic              s_waitrequest;
    logic [DATA_W-1:0] s_readdata;
    logic              s_readdatavalid;
    logic              err_unexpected;

    always #5 clk = ~clk;

    sdram_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MAX_PENDING(MAX_PENDING),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .m0_address(m0_address),
        .m0_read(m0_read),
        .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address),
        .m1_read(m1_read),
        .m1_write(m1_write),
        .m1_writedata(m1_writedata),
        .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address),
        .s_read(s_read),
        .s_write(s_write),
        .s_writedata(s_writedata),
        .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .err_unexpected(err_unexpected)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } resp_t;

    resp_t             resp_q[$];
    logic [DATA_W-1:0] exp_q0[$];
    logic [DATA_W-1:0] exp_q1[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pat_idx = 0;
    int stream_left = 0;
    bit hold = 1'b0;
    bit inj = 1'b0;
    bit pat_en = 1'b0;
    bit s0_on = 1'b0;
    bit s1_on = 1'b0;
    bit acc0 = 1'b0;
    bit acc1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
        if (a == 25'h100)
            return 16'hABCD;
        return a[15:0] ^ 16'hC3A5;
    endfunction

    // Negedge: observe the settled cycle, feed the slave model and the scoreboard.
    task automatic sample();
        acc0 = m0_read && !m0_waitrequest;
        acc1 = (m1_read || m1_write) && !m1_waitrequest;
        if (s_read && !s_waitrequest) begin
            resp_t r;
            r.data = rd_data(s_address);
            r.due  = cyc + LAT;
            resp_q.push_back(r);
            if (pat_en) begin
                check("grant_seq", 32'(acc1), 32'((pat_idx % 17) == 16));
                pat_idx++;
                stream_left--;
            end
        end
        if (acc0)
            exp_q0.push_back(rd_data(m0_address));
        if (acc1 && m1_read)
            exp_q1.push_back(rd_data(m1_address));
        if (m0_readdatavalid) begin
            if (exp_q0.size() == 0) check("m0_rdv_spurious", 32'd1, 32'd0);
            else                    check("m0_rdata", 32'(m0_readdata), 32'(exp_q0.pop_front()));
        end
        if (m1_readdatavalid) begin
            if (exp_q1.size() == 0) check("m1_rdv_spurious", 32'd1, 32'd0);
            else                    check("m1_rdata", 32'(m1_readdata), 32'(exp_q1.pop_front()));
        end
    endtask

    task automatic drive_slave();
        s_readdatavalid = 1'b0;
        s_readdata      = '0;
        if (inj) begin
            s_readdatavalid = 1'b1;
            s_readdata      = 16'hDEAD;
            inj             = 1'b0;
        end else if (!hold && resp_q.size() > 0 && resp_q[0].due <= cyc) begin
            resp_t r;
            r = resp_q.pop_front();
            s_readdatavalid = 1'b1;
            s_readdata      = r.data;
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        sample();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
        cyc++;
        drive_slave();
        if (s0_on) begin
            if (acc0) m0_address = m0_address + 25'd1;
            m0_read = (stream_left > 0);
        end
        if (s1_on) begin
            if (acc1) m1_address = m1_address + 25'd1;
            m1_read = (stream_left > 0);
        end
    endtask

    task automatic tick();
        to_neg();
        to_pos();
    endtask

    task automatic drain();
        int g;
        g = 0;
        hold = 1'b0;
        while ((resp_q.size() > 0 || exp_q0.size() > 0 || exp_q1.size() > 0) && g < 60) begin
            tick();
            g++;
        end
        check("drain_done", 32'(resp_q.size() == 0 && exp_q0.size() == 0 && exp_q1.size() == 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset_n = 1'b0;
        m0_address = '0; m0_read = 1'b0;
        m1_address = '0; m1_read = 1'b0; m1_write = 1'b0;
        m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        to_neg();
        check("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
        check("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
        check("rst_s_read", 32'(s_read), 32'd0);
        check("rst_s_write", 32'(s_write), 32'd0);
        check("rst_err", 32'(err_unexpected), 32'd0);
        check("rst_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
        to_pos();

        // Single m0 read, response 3 cycles later, registered by one cycle
        m0_read = 1'b1; m0_address = 25'h100;
        to_neg();
        check("t1_m0_wait", 32'(m0_waitrequest), 32'd0);
        check("t1_s_read", 32'(s_read), 32'd1);
        check("t1_s_addr", 32'(s_address), 32'h100);
        check("t1_s_be", 32'(s_byteenable), 32'h3);
        to_pos();
        m0_read = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            to_neg();
            check("t1_m0_rdv_early", 32'(m0_readdatavalid), 32'd0);
            to_pos();
        end
        to_neg();
        check("t1_m0_rdv", 32'(m0_readdatavalid), 32'd1);
        check("t1_m0_data", 32'(m0_readdata), 32'hABCD);
        check("t1_m1_rdv", 32'(m1_readdatavalid), 32'd0);
        to_pos();
        drain();

        // Both masters stream reads: 16 m0 grants then one m1 grant, twice
        pat_en = 1'b1; pat_idx = 0; stream_left = 34;
        s0_on = 1'b1; s1_on = 1'b1;
        m0_address = 25'h1000; m1_address = 25'h8000;
        m0_read = 1'b1; m1_read = 1'b1;
        guard = 0;
        while (stream_left > 0 && guard < 200) begin
            tick();
            guard++;
        end
        check("stream_cycles", 32'(guard), 32'd34);
        s0_on = 1'b0; s1_on = 1'b0; pat_en = 1'b0;
        m0_read = 1'b0; m1_read = 1'b0;
        drain();

        // m1 write stalled 4 cycles; m0 arrives in cycle 1 but the grant is locked
        m1_write = 1'b1; m1_address = 25'h20; m1_writedata = 16'h1234; m1_byteenable = 2'b11;
        s_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin m0_read = 1'b1; m0_address = 25'h600; end
            if (i == 4) s_waitrequest = 1'b0;
            to_neg();
            check("t3_s_addr", 32'(s_address), 32'h20);
            check("t3_s_wdata", 32'(s_writedata), 32'h1234);
            check("t3_s_write", 32'(s_write), 32'd1);
            check("t3_s_read", 32'(s_read), 32'd0);
            check("t3_m0_wait", 32'(m0_waitrequest), 32'd1);
            check("t3_m1_wait", 32'(m1_waitrequest), (i == 4) ? 32'd0 : 32'd1);
            to_pos();
        end
        m1_write = 1'b0;
        to_neg();
        check("t3_m0_acc", 32'(m0_waitrequest), 32'd0);
        check("t3_s_read_m0", 32'(s_read), 32'd1);
        check("t3_s_addr_m0", 32'(s_address), 32'h600);
        to_pos();
        m0_read = 1'b0;
        drain();

        // Fill the tag FIFO, then a write passes while the read is blocked
        hold = 1'b1;
        m0_read = 1'b1;
        for (int i = 0; i < MAX_PENDING; i++) begin
            m0_address = 25'h200 + 25'(i);
            to_neg();
            check("t4_fill_acc", 32'(m0_waitrequest), 32'd0);
            to_pos();
        end
        m0_address = 25'h208;
        m1_write = 1'b1; m1_address = 25'h30; m1_writedata = 16'h5555;
        to_neg();
        check("t4_full_m0_wait", 32'(m0_waitrequest), 32'd1);
        check("t4_full_m1_wait", 32'(m1_waitrequest), 32'd0);
        check("t4_full_s_write", 32'(s_write), 32'd1);
        to_pos();
        m1_write = 1'b0;
        to_neg();
        check("t4_still_blocked", 32'(m0_waitrequest), 32'd1);
        check("t4_no_s_read", 32'(s_read), 32'd0);
        hold = 1'b0;
        to_pos();
        to_neg();
        check("t4_pop_cycle_acc", 32'(m0_waitrequest), 32'd0);
        to_pos();
        m0_read = 1'b0;
        drain();

        // Response with nothing pending
        inj = 1'b1;
        tick();
        to_neg();
        check("t5_err_before", 32'(err_unexpected), 32'd0);
        to_pos();
        to_neg();
        check("t5_err_set", 32'(err_unexpected), 32'd1);
        check("t5_no_m0_rdv", 32'(m0_readdatavalid), 32'd0);
        check("t5_no_m1_rdv", 32'(m1_readdatavalid), 32'd0);
        to_pos();
        repeat (3) tick();
        to_neg();
        check("t5_err_sticky", 32'(err_unexpected), 32'd1);
        to_pos();

        // Reset with 3 reads pending and a locked write
        hold = 1'b1;
        m0_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m0_address = 25'h300 + 25'(i);
            tick();
        end
        m0_read = 1'b0;
        m1_write = 1'b1; m1_address = 25'h40; s_waitrequest = 1'b1;
        to_neg();
        check("t6_locked_wait", 32'(m1_waitrequest), 32'd1);
        to_pos();
        reset_n = 1'b0; m0_read = 1'b1; m0_address = 25'h500; s_waitrequest = 1'b0;
        to_neg();
        check("t6_rst_s_read", 32'(s_read), 32'd0);
        check("t6_rst_s_write", 32'(s_write), 32'd0);
        check("t6_rst_m0_wait", 32'(m0_waitrequest), 32'd1);
        check("t6_rst_m1_wait", 32'(m1_waitrequest), 32'd1);
        to_pos();
        resp_q.delete(); exp_q0.delete(); exp_q1.delete();
        reset_n = 1'b1; m1_write = 1'b0;
        to_neg();
        check("t6_first_acc", 32'(m0_waitrequest), 32'd0);
        check("t6_err_cleared", 32'(err_unexpected), 32'd0);
        to_pos();
        m0_read = 1'b0;
        tick();
        drain();
        inj = 1'b1;
        tick();
        tick();
        to_neg();
        check("t6_fifo_was_empty", 32'(err_unexpected), 32'd1);
        check("t6_no_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
        to_pos();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-master Avalon-MM arbiter that shares the single SDRAM controller port of FlightGPA_System between the VGA scan-out reader (master 0) and the rasterizer/frame-clear engine (master 1). It sits in the system clock domain between both masters and the SDRAM controller slave. It gives the display path fixed priority, with a starvation guard for the rasterizer. It tracks outstanding pipelined reads so each read response is routed back to the master that issued it.

## Interface
- ADDR_W, 25, word address width (32M x 16 SDRAM)
- DATA_W, 16, data width; byteenable width is DATA_W/8
- MAX_PENDING, 8, outstanding-read capacity (power of 2, ≥2)
- STARVE_LIMIT, 16, consecutive lost-arbitration cycles before master 1 is promoted

- clk  in  1  system clock (sys_ref_clk domain)
- reset_n  in  1  synchronous, active-low reset
- m0_address  in  ADDR_W  display read address
- m0_read  in  1  display read request
- m0_waitrequest  out  1  stall to display master
- m0_readdata  out  DATA_W  display read data
- m0_readdatavalid  out  1  display read data valid
- m1_address  in  ADDR_W  rasterizer address
- m1_read, m1_write  in  1  rasterizer request; never both high
- m1_writedata  in  DATA_W  rasterizer write data
- m1_byteenable  in  DATA_W/8  rasterizer byte enables
- m1_waitrequest  out  1  stall to rasterizer
- m1_readdata  out  DATA_W  rasterizer read data
- m1_readdatavalid  out  1  rasterizer read data valid
- s_address  out  ADDR_W  to SDRAM controller
- s_read, s_write  out  1  command strobes
- s_writedata  out  DATA_W; s_byteenable out DATA_W/8
- s_waitrequest  in  1  controller stall
- s_readdata  in  DATA_W; s_readdatavalid  in  1
- err_unexpected  out  1  sticky: readdatavalid arrived with no read pending

## Operation
- Grant register: NONE, M0, M1. Plus lock bit.
- Unlocked: grant is picked from the current requests in the same cycle:
  - M1 if m1 is requesting and the starve counter has reached STARVE_LIMIT.
  - Otherwise M0 if m0_read.
  - Otherwise M1 if m1 is requesting.
  - Otherwise NONE.
- A read request is eligible only when the tag FIFO is not full. A write is always eligible.
- s_* command outputs mux the granted master's signals. With grant NONE: s_read=s_write=0, s_byteenable=0. s_address and s_writedata are don't-care.
- Accept = (s_read|s_write) & !s_waitrequest.
  - Granted master's waitrequest = s_waitrequest.
  - Non-granted master's waitrequest = 1.
  - A master with no request sees waitrequest=1.
- Lock: set when a granted command is not accepted; cleared on accept. While locked, the grant is frozen, even if m0 arrives. The Avalon hold rule forbids dropping a presented command.
- Tag FIFO: MAX_PENDING x 1 bit, 0=M0, 1=M1. Push the grant id on each accepted read. Writes never push.
- Response: on s_readdatavalid, pop the FIFO head and route the data to that master. If the FIFO is empty, drop the data and set err_unexpected.
- Push and pop in the same cycle are legal in every occupancy state, including full: occupancy is unchanged and a read is eligible even when full if a pop occurs that cycle.
- Starve counter (width clog2(STARVE_LIMIT+1)):
  - Increments, saturating at STARVE_LIMIT, each cycle m1 requests and is not accepted.
  - Clears on an m1 accept or when m1 is idle.

## Timing
- Command path is combinational: zero added latency. A request can be accepted in its first cycle.
- Read response path is registered: m*_readdata and m*_readdatavalid appear 1 cycle after s_readdatavalid.
- Back-to-back accepts from alternating masters are allowed every cycle (full throughput).
- Reset (reset_n=0 at a clk edge):
  - Clears grant, lock, FIFO, starve counter, err_unexpected and registered readdatavalid.
  - Forces s_read=s_write=0 and m0/m1_waitrequest=1 while reset_n=0.
  - In-flight SDRAM responses arriving after reset release are discarded and flagged.
- Err_unexpected stays set until reset.

## Test plan
- m0 reads 0x100 alone, s_waitrequest=0, controller returns 0xABCD 3 cycles later -> accept in cycle 0; m0_readdatavalid=1 with 0xABCD exactly 1 cycle after s_readdatavalid; m1 sees nothing.
- m0 and m1 both read continuously, STARVE_LIMIT=16 -> m0 is granted 16 consecutive cycles, then m1 is granted exactly once, then the pattern repeats. All 34 responses are routed in issue order to the correct master.
- m1 write 0x1234 to 0x20, s_waitrequest high 4 cycles, m0_read rises in cycle 1 -> grant stays M1 until accept in cycle 4; s_address/s_writedata stable throughout; m0 is accepted in cycle 5. No FIFO push for the write.
- 8 reads accepted with no responses (FIFO full) -> next m0 read holds waitrequest=1 while an m1 write in the same cycle is accepted. When s_readdatavalid pops, the blocked read is accepted in the same cycle.
- s_readdatavalid with FIFO empty -> no m*_readdatavalid; err_unexpected=1 next cycle and sticky until reset_n=0.
- reset_n pulled low with 3 reads pending and lock set -> next cycle s_read=s_write=0, both waitrequests=1, FIFO empty; after release, an m0 read is accepted on its first cycle.
